// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave countdown front end: key codes,
// controller state encodings and the M:SS entry record.
package microwave_pkg;

   localparam logic [3:0] KEY_CLEAR    = 4'd10;
   localparam logic [3:0] KEY_START    = 4'd11;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ENTRY = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   typedef struct packed {
      logic [3:0] min_ones;
      logic [3:0] sec_tens;
      logic [3:0] sec_ones;
   } entry_t;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/entry_shifter.sv
// Three-digit M:SS entry register: keys shift in from the right, the oldest
// minutes digit falls off. Flags a blank entry and an out-of-range seconds tens.
module entry_shifter
   import microwave_pkg::*;
(
   input  logic         clk,
   input  logic         clrn,
   input  logic         clr,
   input  logic         shift,
   input  logic [3:0]   din,
   output entry_t       digits,
   output logic         all_zero,
   output logic         range_ok
);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         digits <= '0;
      end else if (clr) begin
         digits <= '0;
      end else if (shift) begin
         digits.min_ones <= digits.sec_tens;
         digits.sec_tens <= digits.sec_ones;
         digits.sec_ones <= din;
      end
   end

   assign all_zero = (digits == '0);
   assign range_ok = (digits.sec_tens <= SEC_TENS_MAX);

endmodule

// File: rtl/timer_loader.sv
// Keypad-driven loader for the M:SS down-counter chain: collects and checks
// the entry, pulses loadn for one cycle, then gates en with the 1 Hz tick.
module timer_loader
   import microwave_pkg::*;
(
   input  logic         clk,
   input  logic         clrn,
   input  logic         tick,
   input  logic         key_valid,
   input  logic [3:0]   key_code,
   input  logic         timer_zero,
   output logic [3:0]   min_ones,
   output logic [3:0]   sec_tens,
   output logic [3:0]   sec_ones,
   output logic         loadn,
   output logic         en,
   output logic         busy,
   output logic         done,
   output logic         err
);

   logic [2:0] state, state_nxt;
   logic       key_digit, key_clear, key_start, key_any;
   logic       dig_clr, dig_shift, reject;
   logic       all_zero, range_ok;
   entry_t     digits;

   assign key_digit = key_valid & is_digit(key_code);
   assign key_clear = key_valid & (key_code == KEY_CLEAR);
   assign key_start = key_valid & (key_code == KEY_START);
   assign key_any   = key_digit | key_clear | key_start;

   entry_shifter u_entry (
      .clk      (clk),
      .clrn     (clrn),
      .clr      (dig_clr),
      .shift    (dig_shift),
      .din      (key_code),
      .digits   (digits),
      .all_zero (all_zero),
      .range_ok (range_ok)
   );

   always_comb begin
      state_nxt = state;
      dig_clr   = 1'b0;
      dig_shift = 1'b0;
      reject    = 1'b0;
      case (state)
         S_IDLE, S_ENTRY: begin
            if (key_clear) begin
               dig_clr   = 1'b1;
               state_nxt = S_IDLE;
            end else if (key_digit) begin
               dig_shift = 1'b1;
               state_nxt = S_ENTRY;
            end else if (key_start && state == S_ENTRY) begin
               if (!range_ok)
                  reject = 1'b1;
               else if (!all_zero)
                  state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (key_clear) begin
               dig_clr   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (key_clear) begin
               dig_clr   = 1'b1;
               state_nxt = S_IDLE;
            end else if (timer_zero) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            // any real key acknowledges completion and is not shifted in
            if (key_any) begin
               dig_clr   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            dig_clr   = 1'b1;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state <= S_IDLE;
         loadn <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         loadn <= (state_nxt != S_LOAD);
         busy  <= (state_nxt == S_LOAD) || (state_nxt == S_RUN);
         done  <= (state_nxt == S_DONE);
         err   <= reject;
      end
   end

   // Counters only capture load data while enabled, so LOAD asserts en too.
   assign en = ~key_clear &
               ((state == S_LOAD) | ((state == S_RUN) & tick & ~timer_zero));

   assign min_ones = digits.min_ones;
   assign sec_tens = digits.sec_tens;
   assign sec_ones = digits.sec_ones;

endmodule
